// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared codes, segment patterns and anode selects for the 7-segment display path
// Purpose: constants used by the scan driver and by any other user of seg_code_decoder.
// Ports: none (package).
package seg_pkg;

    // Non-numeric digit codes understood by the decoder
    localparam logic [3:0] SEG_MINUS = 4'd10;
    localparam logic [3:0] SEG_BLANK = 4'd11;
    localparam logic [3:0] SEG_E     = 4'd12;
    localparam logic [3:0] SEG_R     = 4'd13;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_MINUS = 7'h3F;
    localparam logic [6:0] PAT_BLANK = 7'h7F;
    localparam logic [6:0] PAT_E     = 7'h06;
    localparam logic [6:0] PAT_R     = 7'h2F;

    // Active-low one-hot anode selects, digit3 is leftmost
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] an;
        an = AN_OFF;
        case (idx)
            2'd3: an = AN_D3;
            2'd2: an = AN_D2;
            2'd1: an = AN_D1;
            2'd0: an = AN_D0;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_code_decoder.sv
// rtl/seg_code_decoder.sv - 4-bit display code to active-low 7-segment pattern
// Purpose: purely combinational lookup, shared by every display user.
// Ports: code [3:0] in  - digit code (0-9, 10 '-', 11 blank, 12 'E', 13/14 'r', 15 blank)
//        pattern [6:0] out - active-low {g,f,e,d,c,b,a}
module seg_code_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = PAT_BLANK;
        case (code)
            4'd0:      pattern = PAT_0;
            4'd1:      pattern = PAT_1;
            4'd2:      pattern = PAT_2;
            4'd3:      pattern = PAT_3;
            4'd4:      pattern = PAT_4;
            4'd5:      pattern = PAT_5;
            4'd6:      pattern = PAT_6;
            4'd7:      pattern = PAT_7;
            4'd8:      pattern = PAT_8;
            4'd9:      pattern = PAT_9;
            SEG_MINUS: pattern = PAT_MINUS;
            SEG_BLANK: pattern = PAT_BLANK;
            SEG_E:     pattern = PAT_E;
            SEG_R:     pattern = PAT_R;
            4'd14:     pattern = PAT_R;
            default:   pattern = PAT_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with frame snapshot
// Purpose: steps through digit3..digit0 one slot at a time, blanking at each slot start,
//          showing a per-frame snapshot of the digit inputs with optional leading-zero blanking.
// Ports: clk_in, rst_n (async active-low)
//        digit3..digit0 [3:0], dp_mask [3:0], lz_en, disp_en   in
//        frame_start (1-cycle pulse per snapshot), Anode_Activate [3:0] (active-low),
//        seg [7:0] (active-low {dp,g,f,e,d,c,b,a})                       out
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_mask,
    input  logic       lz_en,
    input  logic       disp_en,
    output logic       frame_start,
    output logic [3:0] Anode_Activate,
    output logic [7:0] seg
);

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_cnt_nxt;
    logic          slot_wrap;
    logic [1:0]    idx;
    logic          snap_pend;
    logic          snap;

    logic [3:0]    sh_d3, sh_d2, sh_d1, sh_d0;
    logic [3:0]    sh_dp;
    logic          sh_lz;

    slot_state_t   st, st_nxt;

    logic          lz3, lz2, lz1;
    logic [3:0]    raw_code;
    logic          force_blank;
    logic [3:0]    code_sel;
    logic          dp_sel;
    logic [6:0]    pattern;

    // Prescaler and snapshot timing. snap_pend makes the first cycle after
    // reset release take a snapshot even though idx has not wrapped yet.
    always_comb begin
        slot_wrap    = (slot_cnt == CNT_LAST);
        slot_cnt_nxt = slot_wrap ? '0 : slot_cnt + CW'(1);
        snap         = snap_pend || (slot_wrap && (idx == 2'd0));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            idx       <= 2'd3;
            snap_pend <= 1'b1;
        end else begin
            slot_cnt  <= slot_cnt_nxt;
            snap_pend <= 1'b0;
            if (slot_wrap) begin
                idx <= idx - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sh_d3 <= SEG_BLANK;
            sh_d2 <= SEG_BLANK;
            sh_d1 <= SEG_BLANK;
            sh_d0 <= SEG_BLANK;
            sh_dp <= 4'b0000;
            sh_lz <= 1'b0;
        end else if (snap) begin
            sh_d3 <= digit3;
            sh_d2 <= digit2;
            sh_d1 <= digit1;
            sh_d0 <= digit0;
            sh_dp <= dp_mask;
            sh_lz <= lz_en;
        end
    end

    // BLANK/SHOW state tracks the phase of the current slot_cnt value, so the
    // output registers below lag the counter by exactly one cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = ST_SHOW;
        if ((BLANK_CYCLES > 0) && (int'(slot_cnt_nxt) < BLANK_CYCLES)) begin
            st_nxt = ST_BLANK;
        end
    end

    // A digit is a leading zero only if every digit to its left is one too
    always_comb begin
        lz3 = sh_lz && (sh_d3 == 4'd0);
        lz2 = lz3 && (sh_d2 == 4'd0);
        lz1 = lz2 && (sh_d1 == 4'd0);
        raw_code    = sh_d0;
        force_blank = 1'b0;
        case (idx)
            2'd3: begin raw_code = sh_d3; force_blank = lz3;  end
            2'd2: begin raw_code = sh_d2; force_blank = lz2;  end
            2'd1: begin raw_code = sh_d1; force_blank = lz1;  end
            default: begin raw_code = sh_d0; force_blank = 1'b0; end
        endcase
        code_sel = force_blank ? SEG_BLANK : raw_code;
        dp_sel   = sh_dp[idx];
    end

    seg_code_decoder u_dec (
        .code    (code_sel),
        .pattern (pattern)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_start    <= 1'b0;
            Anode_Activate <= AN_OFF;
            seg            <= 8'hFF;
        end else begin
            frame_start <= snap;
            if (disp_en && (st == ST_SHOW)) begin
                Anode_Activate <= anode_for(idx);
                seg            <= {~dp_sel, pattern};
            end else begin
                Anode_Activate <= AN_OFF;
                seg            <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [3:0] dp_mask;
    logic       lz_en;
    logic       disp_en;
    logic       frame_start;
    logic [3:0] Anode_Activate;
    logic [7:0] seg;

    always #5 clk_in = ~clk_in;

    seg_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .digit3         (digit3),
        .digit2         (digit2),
        .digit1         (digit1),
        .digit0         (digit0),
        .dp_mask        (dp_mask),
        .lz_en          (lz_en),
        .disp_en        (disp_en),
        .frame_start    (frame_start),
        .Anode_Activate (Anode_Activate),
        .seg            (seg)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         k        = 0;   // clock edges since reset release
    logic [3:0] m_d [4];
    logic [3:0] m_dp;
    logic       m_lz;
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h7F};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic m_blank(input int di);
        if (!m_lz || di == 0) return 1'b0;
        for (int j = 3; j >= di; j--) begin
            if (m_d[j] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_onehot();
        check("onehot", {15'd0, (Anode_Activate inside {4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110})}, 16'd1);
    endtask

    // One clock: predict this edge's registered outputs, then compare at the falling edge
    task automatic tick();
        exp_t e;
        int   p;
        int   di;
        @(posedge clk_in);
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.fs  = 1'b0;
        if (rst_n) begin
            k++;
            p  = (k - 1) % RD;
            di = 3 - (((k - 1) / RD) % 4);
            if (disp_en && p >= BC) begin
                e.an  = ~(4'b0001 << di);
                e.seg = {~m_dp[di], (m_blank(di) ? 7'h7F : tbl[m_d[di]])};
            end
            e.fs = (k == 1) || (k % (4 * RD) == 0);
            if (e.fs) begin
                m_d[3] = digit3; m_d[2] = digit2; m_d[1] = digit1; m_d[0] = digit0;
                m_dp = dp_mask;
                m_lz = lz_en;
            end
        end else begin
            k = 0;
            for (int j = 0; j < 4; j++) m_d[j] = 4'd11;
            m_dp = 4'd0;
            m_lz = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk_in);
        e = sb.pop_front();
        check("anode", {12'd0, Anode_Activate}, {12'd0, e.an});
        check("seg", {8'd0, seg}, {8'd0, e.seg});
        check("frame_start", {15'd0, frame_start}, {15'd0, e.fs});
        check_onehot();
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        digit3 = a; digit2 = b; digit1 = c; digit0 = d;
    endtask

    initial begin
        logic found;
        rst_n   = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        dp_mask = 4'b0000;
        lz_en   = 1'b0;
        disp_en = 1'b1;

        // 1. reset held, release, first frame 1234
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        repeat (6) begin
            tick();
            check("t1_d3_seg", {8'd0, seg}, 16'h00F9);
        end
        repeat (24) tick();

        // 2. leading-zero blanking
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        lz_en = 1'b1;
        repeat (64) tick();
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (64) tick();
        lz_en = 1'b0;
        repeat (64) tick();

        // 3. decimal point on digit3
        set_digits(4'd7, 4'd0, 4'd0, 4'd0);
        dp_mask = 4'b1000;
        repeat (64) tick();

        // 4. mid-frame input change during the d2 slot
        set_digits(4'd9, 4'd8, 4'd6, 4'd2);
        dp_mask = 4'b0000;
        repeat (64) tick();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (((k / RD) % 4) == 1 && (k % RD) == 4) found = 1'b1;
            else tick();
        end
        check("t4_wait_d2", {15'd0, found}, 16'd1);
        set_digits(4'd0, 4'd0, 4'd3, 4'd1);
        dp_mask = 4'b0101;
        lz_en   = 1'b1;
        repeat (64) tick();

        // 5. display disabled for 20 cycles mid-slot
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((k % RD) == 4) found = 1'b1;
            else tick();
        end
        check("t5_wait_mid", {15'd0, found}, 16'd1);
        disp_en = 1'b0;
        repeat (20) tick();
        disp_en = 1'b1;
        repeat (40) tick();

        // 6. async reset during d1 SHOW
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (((k / RD) % 4) == 2 && (k % RD) == 4) found = 1'b1;
            else tick();
        end
        check("t6_wait_d1", {15'd0, found}, 16'd1);
        check("t6_d1_lit", {12'd0, Anode_Activate}, 16'h000D);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_an", {12'd0, Anode_Activate}, 16'h000F);
        check("t6_async_seg", {8'd0, seg}, 16'h00FF);
        check("t6_async_fs", {15'd0, frame_start}, 16'd0);
        check_onehot();
        repeat (2) tick();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        dp_mask = 4'b0000;
        lz_en   = 1'b0;
        rst_n   = 1'b1;
        repeat (2) tick();
        tick();
        check("t6_restart_d3", {12'd0, Anode_Activate}, 16'h0007);
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
